// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between three requesters:
//   - CPU stores, posted into a small write buffer so the CPU never stalls
//   - the VGA display read port (fixed two-cycle read latency)
//   - the IO (switches/keyboard) write port, with starvation protection
//
// Ports
//   clk, resetN                          clock, synchronous active-low reset
//   cpu_wr_en/cpu_wr_addr/cpu_wr_data    CPU store, pushed into the buffer the same cycle
//   cpu_wbuf_full                        write buffer holds WBUF_DEPTH entries
//   vga_req/vga_addr, vga_gnt            display read request and its grant
//   vga_rvalid/vga_rdata                 read data return, two cycles after vga_gnt
//   io_req/io_addr/io_wdata, io_gnt      IO write request and its grant
//   mem_addr/mem_wdata/mem_wren          registered RAM command
//   mem_rdata                            RAM read data, one cycle after a read command
//   dbgWbufCount, dbgIoWait              buffer occupancy and IO wait counter (observability)
//
// Request/grant handshake: a requester raises *_req with its address/data
// stable and keeps them stable until it sees *_gnt high in the same cycle;
// the transfer is accepted on that clock edge. Grants are combinational
// from the current requests and the arbiter state, and at most one grant
// is high in any cycle.

module mem_port_arbiter #(
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 16,
   parameter int WBUF_DEPTH  = 4,
   parameter int IO_MAX_WAIT = 8,
   localparam int PTR_W      = $clog2(WBUF_DEPTH),
   localparam int CNT_W      = PTR_W + 1,
   localparam int WAIT_W     = $clog2(IO_MAX_WAIT + 1)
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              cpu_wr_en,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic              cpu_wbuf_full,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              io_req,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  dbgWbufCount,
   output logic [WAIT_W-1:0] dbgIoWait
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_IO   = 2'd2,
      GNT_VGA  = 2'd3
   } grantSel_t;

   // ------------------------------------------------------------------
   // Posted write buffer
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] wbufAddr [WBUF_DEPTH];
   logic [DATA_W-1:0] wbufData [WBUF_DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  wbufCount;
   logic              wbufFull;
   logic              wbufEmpty;
   logic              pushEn;
   logic              popEn;
   logic [ADDR_W-1:0] headAddr;
   logic [DATA_W-1:0] headData;

   // IO starvation counter
   logic [WAIT_W-1:0] ioWait;
   logic              ioStarving;

   // Arbitration result and read pipeline
   grantSel_t grantSel;
   logic      vgaPend;

   assign wbufFull   = (wbufCount == CNT_W'(WBUF_DEPTH));
   assign wbufEmpty  = (wbufCount == '0);
   assign ioStarving = (ioWait == WAIT_W'(IO_MAX_WAIT));

   // Stores are ignored while reset is asserted.
   assign pushEn = resetN && cpu_wr_en;
   assign popEn  = (grantSel == GNT_CPU);

   // The head is read before this cycle's push lands, so a push into a
   // full buffer (which always coincides with a drain) overwrites the slot
   // only after the old head has been handed to the RAM command register.
   assign headAddr = wbufAddr[rdPtr];
   assign headData = wbufData[rdPtr];

   // ------------------------------------------------------------------
   // Arbitration: a full buffer must drain first so a same-cycle push can
   // never overflow; a starving IO request then beats the display.
   // ------------------------------------------------------------------
   always_comb begin
      grantSel = GNT_NONE;
      if (!resetN) begin
         grantSel = GNT_NONE;
      end else if (wbufFull) begin
         grantSel = GNT_CPU;
      end else if (io_req && ioStarving) begin
         grantSel = GNT_IO;
      end else if (vga_req) begin
         grantSel = GNT_VGA;
      end else if (!wbufEmpty) begin
         grantSel = GNT_CPU;
      end else if (io_req) begin
         grantSel = GNT_IO;
      end
   end

   always_comb begin
      vga_gnt = (grantSel == GNT_VGA);
      io_gnt  = (grantSel == GNT_IO);
   end

   // ------------------------------------------------------------------
   // Write buffer storage and pointers (power-of-two depth, so the
   // pointers wrap naturally).
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (pushEn) begin
         wbufAddr[wrPtr] <= cpu_wr_addr;
         wbufData[wrPtr] <= cpu_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         wbufCount <= '0;
      end else begin
         if (pushEn) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (popEn) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         case ({pushEn, popEn})
            2'b10:   wbufCount <= wbufCount + CNT_W'(1);
            2'b01:   wbufCount <= wbufCount - CNT_W'(1);
            default: wbufCount <= wbufCount;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // IO wait counter: counts cycles an IO request has been refused,
   // saturating at the starvation threshold.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetN) begin
         ioWait <= '0;
      end else if (!io_req || io_gnt) begin
         ioWait <= '0;
      end else if (!ioStarving) begin
         ioWait <= ioWait + WAIT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Registered RAM command. With no grant the address/data hold so the
   // RAM inputs do not toggle needlessly.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetN) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wren  <= 1'b0;
      end else begin
         case (grantSel)
            GNT_CPU: begin
               mem_addr  <= headAddr;
               mem_wdata <= headData;
               mem_wren  <= 1'b1;
            end
            GNT_IO: begin
               mem_addr  <= io_addr;
               mem_wdata <= io_wdata;
               mem_wren  <= 1'b1;
            end
            GNT_VGA: begin
               mem_addr  <= vga_addr;
               mem_wren  <= 1'b0;
            end
            default: begin
               mem_wren  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read return: grant -> command cycle (vgaPend) -> data cycle
   // (vga_rvalid). The RAM presents data in the data cycle, so the data is
   // forwarded straight through and forced to zero when not valid.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetN) begin
         vgaPend    <= 1'b0;
         vga_rvalid <= 1'b0;
      end else begin
         vgaPend    <= (grantSel == GNT_VGA);
         vga_rvalid <= vgaPend;
      end
   end

   assign vga_rdata     = vga_rvalid ? mem_rdata : '0;
   assign cpu_wbuf_full = wbufFull;
   assign dbgWbufCount  = wbufCount;
   assign dbgIoWait     = ioWait;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a grant-priority vector table plus
// hand-written sequences for the posted-write, starvation, read-latency
// and reset corner cases. A behavioural RAM sits on the memory port, and a
// negedge monitor scores every RAM write and every read return.

module tb_mem_port_arbiter;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 3;
   localparam int WAIT_W = 4;

   // ------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------
   logic              clk;
   logic              resetN;
   logic              cpu_wr_en;
   logic [ADDR_W-1:0] cpu_wr_addr;
   logic [DATA_W-1:0] cpu_wr_data;
   logic              cpu_wbuf_full;
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_gnt;
   logic              vga_rvalid;
   logic [DATA_W-1:0] vga_rdata;
   logic              io_req;
   logic [ADDR_W-1:0] io_addr;
   logic [DATA_W-1:0] io_wdata;
   logic              io_gnt;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_rdata;
   logic [CNT_W-1:0]  dbgWbufCount;
   logic [WAIT_W-1:0] dbgIoWait;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   mem_port_arbiter dut (
      .clk           (clk),
      .resetN        (resetN),
      .cpu_wr_en     (cpu_wr_en),
      .cpu_wr_addr   (cpu_wr_addr),
      .cpu_wr_data   (cpu_wr_data),
      .cpu_wbuf_full (cpu_wbuf_full),
      .vga_req       (vga_req),
      .vga_addr      (vga_addr),
      .vga_gnt       (vga_gnt),
      .vga_rvalid    (vga_rvalid),
      .vga_rdata     (vga_rdata),
      .io_req        (io_req),
      .io_addr       (io_addr),
      .io_wdata      (io_wdata),
      .io_gnt        (io_gnt),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wren      (mem_wren),
      .mem_rdata     (mem_rdata),
      .dbgWbufCount  (dbgWbufCount),
      .dbgIoWait     (dbgIoWait)
   );

   // ------------------------------------------------------------------
   // Behavioural RAM: unwritten locations return a fixed pattern, with
   // 0x1234 preloaded at 0x0100.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] ramMem     [0:(1<<ADDR_W)-1];
   bit                ramWritten [0:(1<<ADDR_W)-1];

   function automatic logic [DATA_W-1:0] ramPattern(input logic [ADDR_W-1:0] a);
      if (a == 15'h0100) return 16'h1234;
      return {a, 1'b0} ^ 16'hA5C3;
   endfunction

   function automatic logic [DATA_W-1:0] ramRead(input logic [ADDR_W-1:0] a);
      if (ramWritten[a]) return ramMem[a];
      return ramPattern(a);
   endfunction

   always @(posedge clk) begin
      if (mem_wren === 1'b1) begin
         ramMem[mem_addr]     <= mem_wdata;
         ramWritten[mem_addr] <= 1'b1;
      end
      mem_rdata <= ramRead(mem_addr);
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   logic [ADDR_W+DATA_W-1:0] exp_q[$];     // CPU stores, push order
   logic [ADDR_W-1:0]        rdAddrQ[$];   // granted VGA read addresses

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: one grant per cycle, writes in grant order, read command one
   // cycle after grant, read data two cycles after grant.
   logic                     prevIoGnt  = 1'b0;
   logic                     prevVgaGnt = 1'b0;
   logic [ADDR_W+DATA_W-1:0] prevIoCmd  = '0;
   logic [ADDR_W-1:0]        prevVgaAddr = '0;

   always @(negedge clk) begin
      if (vga_gnt === 1'b1 && io_gnt === 1'b1) begin
         check("single_grant", 32'd1, 32'd0);
      end
      if (prevVgaGnt) begin
         check("read_cmd_wren", 32'(mem_wren), 32'd0);
         check("read_cmd_addr", 32'(mem_addr), 32'(prevVgaAddr));
      end
      if (mem_wren === 1'b1) begin
         if (prevIoGnt) begin
            check("io_write", 32'({mem_addr, mem_wdata}), 32'(prevIoCmd));
         end else if (exp_q.size() > 0) begin
            check("cpu_write", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
         end else begin
            check("spurious_write", 32'd1, 32'd0);
         end
      end
      if (vga_rvalid === 1'b1) begin
         if (rdAddrQ.size() > 0) begin
            check("read_data", 32'(vga_rdata), 32'(ramRead(rdAddrQ.pop_front())));
         end else begin
            check("spurious_rvalid", 32'd1, 32'd0);
         end
      end
      if (vga_gnt === 1'b1) rdAddrQ.push_back(vga_addr);
      if (io_gnt === 1'b1) prevIoCmd = {io_addr, io_wdata};
      prevIoGnt   = (io_gnt === 1'b1);
      prevVgaGnt  = (vga_gnt === 1'b1);
      prevVgaAddr = vga_addr;
   end

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   task automatic doReset();
      resetN = 1'b0;
      @(posedge clk);
      exp_q.delete();
      rdAddrQ.delete();
      #1 resetN = 1'b1;
   endtask

   task automatic pushStore(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cpu_wr_en   = 1'b1;
      cpu_wr_addr = a;
      cpu_wr_data = d;
      exp_q.push_back({a, d});
      @(posedge clk);
      #1 cpu_wr_en = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Grant priority table: preload `pre` buffered stores (VGA holds the
   // port meanwhile), then apply the requests for one cycle.
   // ------------------------------------------------------------------
   typedef struct {
      int   pre;
      logic vga;
      logic io;
      logic expVgaGnt;
      logic expIoGnt;
      logic expFull;
      int   expCount;
   } vec_t;

   vec_t vecs[10];

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int ioCycle;

      //            pre vga io  vGnt iGnt full count-after
      vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[1] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[2] = '{0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
      vecs[3] = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      vecs[4] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[5] = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      vecs[6] = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[7] = '{4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3};
      vecs[8] = '{4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      vecs[9] = '{3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3};

      resetN      = 1'b0;
      cpu_wr_en   = 1'b0;
      cpu_wr_addr = '0;
      cpu_wr_data = '0;
      vga_req     = 1'b1;
      vga_addr    = 15'h0040;
      io_req      = 1'b1;
      io_addr     = 15'h0050;
      io_wdata    = 16'h5555;

      // Reset state, with requests asserted during reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_wren",   32'(mem_wren), 32'd0);
      check("rst_mem_addr",   32'(mem_addr), 32'd0);
      check("rst_mem_wdata",  32'(mem_wdata), 32'd0);
      check("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
      check("rst_vga_rdata",  32'(vga_rdata), 32'd0);
      check("rst_full",       32'(cpu_wbuf_full), 32'd0);
      check("rst_count",      32'(dbgWbufCount), 32'd0);
      check("rst_io_wait",    32'(dbgIoWait), 32'd0);
      check("rst_vga_gnt",    32'(vga_gnt), 32'd0);
      check("rst_io_gnt",     32'(io_gnt), 32'd0);

      // First grant in the first cycle out of reset
      @(posedge clk);
      #1 resetN = 1'b1;
      io_req = 1'b0;
      @(negedge clk);
      check("first_grant_vga", 32'(vga_gnt), 32'd1);
      nextCycle();
      vga_req = 1'b0;
      repeat (3) nextCycle();

      // Priority table
      for (int v = 0; v < 10; v++) begin
         doReset();
         vga_req  = 1'b1;
         vga_addr = ADDR_W'(15'h0600 + v);
         for (int k = 0; k < vecs[v].pre; k++) begin
            pushStore(ADDR_W'(15'h0700 + 16 * v + k), DATA_W'(16'h7000 + 16 * v + k));
         end
         vga_req  = vecs[v].vga;
         io_req   = vecs[v].io;
         io_addr  = ADDR_W'(15'h0500 + v);
         io_wdata = DATA_W'(16'hA000 + v);
         @(negedge clk);
         check($sformatf("vec%0d_vga_gnt", v), 32'(vga_gnt), 32'(vecs[v].expVgaGnt));
         check($sformatf("vec%0d_io_gnt", v), 32'(io_gnt), 32'(vecs[v].expIoGnt));
         check($sformatf("vec%0d_full", v), 32'(cpu_wbuf_full), 32'(vecs[v].expFull));
         nextCycle();
         vga_req = 1'b0;
         io_req  = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_count", v), 32'(dbgWbufCount), 32'(vecs[v].expCount));
         repeat (6) nextCycle();
      end

      // Single CPU store reaches RAM exactly one cycle after the push
      doReset();
      pushStore(15'h0010, 16'hBEEF);
      @(negedge clk);
      check("store_not_early", 32'(mem_wren), 32'd0);
      nextCycle();
      @(negedge clk);
      check("store_wren",  32'(mem_wren), 32'd1);
      check("store_addr",  32'(mem_addr), 32'h0010);
      check("store_wdata", 32'(mem_wdata), 32'hBEEF);
      repeat (3) nextCycle();

      // Five back-to-back stores against a continuous display read stream
      doReset();
      vga_req  = 1'b1;
      vga_addr = 15'h0200;
      for (int k = 0; k < 5; k++) begin
         cpu_wr_en   = 1'b1;
         cpu_wr_addr = ADDR_W'(15'h0300 + k);
         cpu_wr_data = DATA_W'(16'hC000 + k);
         exp_q.push_back({cpu_wr_addr, cpu_wr_data});
         @(negedge clk);
         if (k == 2 || k == 3) check($sformatf("b2b_rvalid_%0d", k), 32'(vga_rvalid), 32'd1);
         if (k == 3) check("full_before_4", 32'(cpu_wbuf_full), 32'd0);
         if (k == 4) begin
            check("full_at_4",  32'(cpu_wbuf_full), 32'd1);
            check("count_at_4", 32'(dbgWbufCount), 32'd4);
         end
         nextCycle();
      end
      cpu_wr_en = 1'b0;
      @(negedge clk);
      check("push_pop_count",   32'(dbgWbufCount), 32'd4);
      check("push_pop_wren",    32'(mem_wren), 32'd1);
      check("push_pop_oldest",  32'(mem_addr), 32'h0300);
      nextCycle();
      @(negedge clk);
      check("full_released",    32'(cpu_wbuf_full), 32'd0);
      check("count_after_drain", 32'(dbgWbufCount), 32'd3);
      check("second_drain",     32'(mem_addr), 32'h0301);
      repeat (2) nextCycle();
      @(negedge clk);
      check("vga_holds_buffer", 32'(dbgWbufCount), 32'd3);
      nextCycle();
      vga_req = 1'b0;
      repeat (6) nextCycle();
      check("all_stores_landed", 32'(exp_q.size()), 32'd0);

      // IO starvation: VGA and IO both held, buffer empty
      doReset();
      vga_req  = 1'b1;
      vga_addr = 15'h0210;
      io_req   = 1'b1;
      io_addr  = 15'h0220;
      io_wdata = 16'h1F1F;
      ioCycle  = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (io_gnt === 1'b1) begin
            ioCycle = c;
            break;
         end
         nextCycle();
      end
      check("io_gnt_cycle", 32'(ioCycle), 32'd9);
      nextCycle();
      io_req = 1'b0;
      @(negedge clk);
      check("io_wait_cleared", 32'(dbgIoWait), 32'd0);
      nextCycle();
      vga_req = 1'b0;
      repeat (4) nextCycle();

      // Preloaded read: data returns two cycles after the grant
      doReset();
      vga_req  = 1'b1;
      vga_addr = 15'h0100;
      @(negedge clk);
      check("rd_gnt", 32'(vga_gnt), 32'd1);
      nextCycle();
      vga_req = 1'b0;
      @(negedge clk);
      check("rd_cmd_rvalid", 32'(vga_rvalid), 32'd0);
      check("rd_cmd_addr",   32'(mem_addr), 32'h0100);
      nextCycle();
      @(negedge clk);
      check("rd_rvalid", 32'(vga_rvalid), 32'd1);
      check("rd_rdata",  32'(vga_rdata), 32'h1234);
      repeat (2) nextCycle();

      // Reset with buffered writes and reads in flight discards them all
      doReset();
      vga_req  = 1'b1;
      vga_addr = 15'h0230;
      for (int k = 0; k < 3; k++) begin
         pushStore(ADDR_W'(15'h0240 + k), DATA_W'(16'hD000 + k));
      end
      resetN      = 1'b0;
      vga_req     = 1'b0;
      cpu_wr_en   = 1'b1;
      cpu_wr_addr = 15'h0250;
      cpu_wr_data = 16'hDEAD;
      @(negedge clk);
      check("midrst_vga_gnt", 32'(vga_gnt), 32'd0);
      @(posedge clk);
      exp_q.delete();
      rdAddrQ.delete();
      #1 resetN = 1'b1;
      cpu_wr_en = 1'b0;
      @(negedge clk);
      check("midrst_full",  32'(cpu_wbuf_full), 32'd0);
      check("midrst_count", 32'(dbgWbufCount), 32'd0);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("midrst_no_wren_%0d", c), 32'(mem_wren), 32'd0);
         check($sformatf("midrst_no_rvalid_%0d", c), 32'(vga_rvalid), 32'd0);
         nextCycle();
         @(negedge clk);
      end

      check("final_write_queue", 32'(exp_q.size()), 32'd0);
      check("final_read_queue",  32'(rdAddrQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
